// File: rtl/vec_capture_pkg.sv
// ---- vec_capture_pkg: record layout, widths and capture modes | rev 1.0 ----
`default_nettype none

package vec_capture_pkg;

  localparam logic MODE_ALL = 1'b0;
  localparam logic MODE_CHG = 1'b1;

  localparam int REC_WIDTH = 3;
  localparam int REC_TS_W  = 32;

  // Layout at the default geometry; the top rebuilds it at its own WIDTH/TS_W.
  typedef struct packed {
    logic                ovf;
    logic [REC_TS_W-1:0] ts;
    logic [REC_WIDTH-1:0] data;
  } rec_t;

  function automatic int rec_w(input int width, input int ts_w);
    return width + ts_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_capture_fifo.sv
// ---- vec_capture_fifo: synchronous show-ahead FIFO with push/pop and count | rev 1.0 ----
`default_nettype none

module vec_capture_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  output logic                       push_ready_o,
  input  logic                       pop_i,
  output logic                       pop_valid_o,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic [AW:0]       cnt;
  logic              pop_ok, push_ok;

  assign cnt          = wptr_q - rptr_q;
  assign pop_valid_o  = (cnt != '0);
  assign pop_ok       = pop_i & pop_valid_o;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ready_o = (cnt != FULL_CNT) | pop_ok;
  assign push_ok      = push_i & push_ready_o;
  assign count_o      = cnt;
  assign pop_data_o   = pop_valid_o ? mem_q[rptr_q[AW-1:0]] : '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/vec_capture.sv
// ---- vec_capture: timestamped signal-vector capture into a drainable FIFO | rev 1.0 ----
`default_nettype none

module vec_capture
  import vec_capture_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  parameter int DROP_W = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       en,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W-1:0]            out_ts,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_ovf,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DROP_W-1:0]          drops
);

  localparam int REC_W = rec_w(WIDTH, TS_W);

  typedef struct packed {
    logic             ovf;
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] data;
  } cap_rec_t;

  logic [TS_W-1:0]   ts_q;
  logic [WIDTH-1:0]  prev_q;
  logic              first_q;
  logic              ovf_pend_q;
  logic [DROP_W-1:0] drops_q;

  logic              cap, push_ready, push_ok, push_lost;
  cap_rec_t          push_rec, head_rec;
  logic [REC_W-1:0]  head_bits;

  assign cap = en & ((mode == MODE_ALL) | ((mode == MODE_CHG) & (din != prev_q)) | first_q);
  assign push_ok   = cap & push_ready;
  assign push_lost = cap & ~push_ready;

  assign push_rec.ovf  = ovf_pend_q;
  assign push_rec.ts   = ts_q;
  assign push_rec.data = din;

  vec_capture_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .Clk          (Clk),
    .Reset        (Reset),
    .push_i       (cap),
    .push_data_i  (push_rec),
    .push_ready_o (push_ready),
    .pop_i        (out_ready),
    .pop_valid_o  (out_valid),
    .pop_data_o   (head_bits),
    .count_o      (count)
  );

  assign head_rec = head_bits;
  assign out_ts   = head_rec.ts;
  assign out_data = head_rec.data;
  assign out_ovf  = head_rec.ovf;
  assign drops    = drops_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ts_q       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      ovf_pend_q <= 1'b0;
      drops_q    <= '0;
    end else begin
      ts_q    <= ts_q + TS_W'(1);
      // Re-arming on disable guarantees a record at the start of every enabled run.
      first_q <= ~en;
      if (en) prev_q <= din;
      if (push_lost) begin
        ovf_pend_q <= 1'b1;
        if (drops_q != '1) drops_q <= drops_q + DROP_W'(1);
      end else if (push_ok) begin
        ovf_pend_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_capture.sv
// ---- tb_vec_capture: directed self-checking bench for vec_capture | rev 1.0 ----
`default_nettype none

module tb_vec_capture;

  logic        Clk = 1'b0;
  logic        Reset, en, mode, out_ready;
  logic [2:0]  din;

  logic        out_valid, out_ovf;
  logic [31:0] out_ts;
  logic [2:0]  out_data;
  logic [4:0]  count;
  logic [15:0] drops;

  logic        s_valid, s_ovf;
  logic [3:0]  s_ts;
  logic [2:0]  s_data;
  logic [4:0]  s_count;
  logic [15:0] s_drops;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_ts;

  always #5 Clk = ~Clk;

  vec_capture #(.WIDTH(3), .DEPTH(16), .TS_W(32), .DROP_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .en(en), .mode(mode), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
    .out_data(out_data), .out_ovf(out_ovf), .count(count), .drops(drops)
  );

  vec_capture #(.WIDTH(3), .DEPTH(16), .TS_W(4), .DROP_W(16)) dut_ts4 (
    .Clk(Clk), .Reset(Reset), .en(en), .mode(mode), .din(din),
    .out_valid(s_valid), .out_ready(out_ready), .out_ts(s_ts),
    .out_data(s_data), .out_ovf(s_ovf), .count(s_count), .drops(s_drops)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    en    = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; en = 1'b0; mode = 1'b0; din = '0; out_ready = 1'b0;

    // Test 1: every-cycle capture of a ramp with the consumer always ready
    do_reset();
    check_val("rst_valid", out_valid, 0);
    check_val("rst_count", count, 0);
    check_val("rst_drops", drops, 0);
    check_val("rst_ts", out_ts, 0);
    mode = 1'b0; out_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      din = 3'(i); en = 1'b1;
      step();
      check_val("t1_valid", out_valid, 1);
      check_val("t1_ts", out_ts, i + 1);
      check_val("t1_data", out_data, i);
      check_val("t1_ovf", out_ovf, 0);
    end
    en = 1'b0;
    step();
    check_val("t1_empty", out_valid, 0);
    check_val("t1_count", count, 0);
    check_val("t1_drops", drops, 0);

    // Test 2: on-change capture, 5 held for 10 cycles then 6
    do_reset();
    mode = 1'b1; out_ready = 1'b0;
    step();
    en = 1'b1; din = 3'd5;
    for (int i = 0; i < 10; i++) step();
    din = 3'd6;
    step();
    en = 1'b0;
    check_val("t2_count", count, 2);
    check_val("t2_data0", out_data, 5);
    check_val("t2_ts0", out_ts, 1);
    out_ready = 1'b1;
    step();
    check_val("t2_data1", out_data, 6);
    check_val("t2_ts1", out_ts, 11);
    step();
    check_val("t2_empty", out_valid, 0);

    // Tests 3+4: overfill by 4, then drain while still capturing into a full FIFO
    do_reset();
    mode = 1'b0; out_ready = 1'b0;
    step();
    exp_ts = 32'd1;
    for (int i = 0; i < 20; i++) begin
      din = exp_ts[2:0]; en = 1'b1;
      step();
      exp_ts = exp_ts + 1;
    end
    check_val("t3_count_full", count, 16);
    check_val("t3_drops", drops, 4);
    check_val("t3_head_ts", out_ts, 1);
    out_ready = 1'b1;
    for (int j = 0; j < 26; j++) begin
      if (j < 16) begin
        check_val("t3_drain_ts", out_ts, j + 1);
        check_val("t3_drain_data", out_data, (j + 1) % 8);
        check_val("t3_drain_ovf", out_ovf, 0);
      end else begin
        check_val("t4_ts", out_ts, 21 + (j - 16));
        check_val("t4_data", out_data, (21 + (j - 16)) % 8);
        check_val("t4_ovf", out_ovf, (j == 16) ? 1 : 0);
      end
      din = exp_ts[2:0];
      step();
      exp_ts = exp_ts + 1;
      check_val("t4_count", count, 16);
      check_val("t4_drops", drops, 4);
    end

    // Test 5: 4-bit timestamp wraps without disturbing data
    do_reset();
    mode = 1'b0; out_ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = 3'(k);
      step();
      check_val("t5_valid", s_valid, 1);
      check_val("t5_ts", s_ts, k % 16);
      check_val("t5_data", s_data, k % 8);
    end
    en = 1'b0;

    // Test 6: reset with 9 queued records, then first enabled cycle captures
    do_reset();
    mode = 1'b0; out_ready = 1'b0;
    step();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din = 3'(i + 1);
      step();
    end
    en = 1'b0;
    check_val("t6_count9", count, 9);
    do_reset();
    check_val("t6_count", count, 0);
    check_val("t6_valid", out_valid, 0);
    check_val("t6_drops", drops, 0);
    check_val("t6_ts", out_ts, 0);
    check_val("t6_data", out_data, 0);
    check_val("t6_ovf", out_ovf, 0);
    mode = 1'b1; din = 3'd0; en = 1'b1;
    step();
    en = 1'b0;
    check_val("t6_first_valid", out_valid, 1);
    check_val("t6_first_data", out_data, 0);
    check_val("t6_first_ts", out_ts, 0);
    check_val("t6_first_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
